// File: rtl/relogio_dezenas_min_horas.sv
// Tens-of-seconds / minutes / hours stage of the clock chain with debounced time-set buttons.
// Optional build macro: FORMATO_12H_EN (12-hour display plus pm flag).
module relogio_deb #(
  parameter int DEB_CICLOS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic key,
  output logic press
);
  localparam int CW = $clog2(DEB_CICLOS + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   low;

  assign low   = ~sync[SYNC_STAGES-1];
  // Fires once on the DEB_CICLOS-th low sample; the counter then saturates until release.
  assign press = low && (cnt == CW'(DEB_CICLOS - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync <= '1;
      cnt  <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], key};
      if (!low)                        cnt <= '0;
      else if (cnt != CW'(DEB_CICLOS)) cnt <= cnt + CW'(1);
    end
  end
endmodule

module relogio_dezenas_min_horas #(
  parameter int DEB_CICLOS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       carry_in,
  input  logic       ajuste,
  input  logic       KEY_min,
  input  logic       KEY_hora,
  output logic [6:0] hex_sd,
  output logic [6:0] hex_mu,
  output logic [6:0] hex_md,
  output logic [6:0] hex_hu,
  output logic [6:0] hex_hd,
  output logic       carry_out,
  output logic       pm
);
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = 7'b1111111;
    endcase
  endfunction

  logic [1:0] keys, press;
  assign keys = {KEY_hora, KEY_min};

  for (genvar i = 0; i < 2; i++) begin : g_deb
    relogio_deb #(.DEB_CICLOS(DEB_CICLOS), .SYNC_STAGES(SYNC_STAGES)) u_deb (
      .clock (clock),
      .resetn(resetn),
      .key   (keys[i]),
      .press (press[i])
    );
  end

  logic [2:0] sd, md, sd_nx, md_nx;
  logic [3:0] mu, hu, mu_nx, hu_nx;
  logic [1:0] hd, hd_nx;
  logic       sd_wrap, mu_wrap, md_wrap, h_wrap;

  assign sd_wrap = (sd == 3'd5);
  assign mu_wrap = (mu == 4'd9);
  assign md_wrap = (md == 3'd5);
  assign h_wrap  = (hd == 2'd2) && (hu == 4'd3);

  always_comb begin
    sd_nx = sd_wrap ? 3'd0 : sd + 3'd1;
    mu_nx = mu_wrap ? 4'd0 : mu + 4'd1;
    md_nx = md_wrap ? 3'd0 : md + 3'd1;
    hu_nx = hu + 4'd1;
    hd_nx = hd;
    if (h_wrap) begin
      hu_nx = 4'd0;
      hd_nx = 2'd0;
    end else if (hu == 4'd9) begin
      hu_nx = 4'd0;
      hd_nx = hd + 2'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sd <= '0; mu <= '0; md <= '0; hu <= '0; hd <= '0;
      carry_out <= 1'b0;
    end else begin
      carry_out <= 1'b0;
      if (ajuste) begin
        // Set mode: minutes and hours adjust independently, no ripple between them.
        sd <= 3'd0;
        if (press[0]) begin
          mu <= mu_nx;
          if (mu_wrap) md <= md_nx;
        end
        if (press[1]) begin
          hu <= hu_nx;
          hd <= hd_nx;
        end
      end else if (carry_in) begin
        sd <= sd_nx;
        if (sd_wrap) begin
          mu <= mu_nx;
          if (mu_wrap) begin
            md <= md_nx;
            if (md_wrap) begin
              hu        <= hu_nx;
              hd        <= hd_nx;
              carry_out <= h_wrap;
            end
          end
        end
      end
    end
  end

  logic [3:0] dhd, dhu;
  logic       pm_nx;

`ifdef FORMATO_12H_EN
  logic [4:0] hbin, h12;
  always_comb begin
    hbin  = 5'(hd) * 5'd10 + 5'(hu);
    pm_nx = (hbin >= 5'd12);
    h12   = pm_nx ? hbin - 5'd12 : hbin;
    if (h12 == 5'd0) h12 = 5'd12;
    dhd   = (h12 >= 5'd10) ? 4'd1 : 4'd0;
    dhu   = 4'(h12 - ((h12 >= 5'd10) ? 5'd10 : 5'd0));
  end
`else
  always_comb begin
    dhd   = {2'b00, hd};
    dhu   = hu;
    pm_nx = 1'b0;
  end
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hex_sd <= 7'b0000001; hex_mu <= 7'b0000001; hex_md <= 7'b0000001;
      hex_hu <= 7'b0000001; hex_hd <= 7'b0000001;
      pm     <= 1'b0;
    end else begin
      hex_sd <= seg({1'b0, sd});
      hex_mu <= seg(mu);
      hex_md <= seg({1'b0, md});
      hex_hu <= seg(dhu);
      hex_hd <= seg(dhd);
      pm     <= pm_nx;
    end
  end
endmodule

// File: tb/tb_relogio_dezenas_min_horas.sv
// Randomized bench for relogio_dezenas_min_horas against a time-of-day model counted in
// tens of seconds (0..8639); display is expected one clock after the counters.
module tb_relogio_dezenas_min_horas;
  localparam int DEB = 16;
  localparam int SYN = 2;
  localparam logic [6:0] SEG [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                      7'b0000000, 7'b0000100};

  logic clock = 1'b0;
  logic resetn, carry_in, ajuste, KEY_min, KEY_hora;
  logic [6:0] hex_sd, hex_mu, hex_md, hex_hu, hex_hd;
  logic carry_out, pm;

  relogio_dezenas_min_horas #(.DEB_CICLOS(DEB), .SYNC_STAGES(SYN)) dut (
    .clock(clock), .resetn(resetn), .carry_in(carry_in), .ajuste(ajuste),
    .KEY_min(KEY_min), .KEY_hora(KEY_hora),
    .hex_sd(hex_sd), .hex_mu(hex_mu), .hex_md(hex_md), .hex_hu(hex_hu), .hex_hd(hex_hd),
    .carry_out(carry_out), .pm(pm)
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0;
  int t = 0;
  int nco = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0d", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [34:0] exp_hex(input int tt);
    int h = tt / 360;
    int m = (tt / 6) % 60;
    int s = tt % 6;
    int dh = h;
`ifdef FORMATO_12H_EN
    dh = (h % 12 == 0) ? 12 : h % 12;
`endif
    return {SEG[s], SEG[m % 10], SEG[m / 10], SEG[dh % 10], SEG[dh / 10]};
  endfunction

  function automatic logic exp_pm(input int tt);
`ifdef FORMATO_12H_EN
    return (tt / 360) >= 12;
`else
    return 1'b0 & (tt >= 0);
`endif
  endfunction

  // One clock: drive carry_in, advance the model, compare registered outputs.
  task automatic step(input logic ci, input logic chk);
    int  pt;
    logic wrap;
    carry_in = ci;
    @(posedge clock); #1;
    carry_in = 1'b0;
    pt   = t;
    wrap = 1'b0;
    if (ajuste) t = t - t % 6;
    else if (ci) begin
      t    = (t + 1) % 8640;
      wrap = (t == 0);
    end
    if (chk) begin
      if (carry_out === 1'b1) nco++;
      check("carry", carry_out, wrap);
      check("hex", {hex_sd, hex_mu, hex_md, hex_hu, hex_hd}, exp_hex(pt));
      check("pm", pm, exp_pm(pt));
    end
  endtask

  task automatic press(input logic km, input logic kh, input int n, input logic chk);
    KEY_min  = ~km;
    KEY_hora = ~kh;
    repeat (n) step($urandom_range(0, 3) == 0, chk);
    KEY_min  = 1'b1;
    KEY_hora = 1'b1;
    if (ajuste && n >= DEB + SYN) begin
      if (km) t = (t / 360) * 360 + ((((t / 6) % 60) + 1) % 60) * 6;
      if (kh) t = (((t / 360) + 1) % 24) * 360 + t % 360;
    end
    step(1'b0, chk);
    repeat (3) step(1'b0, 1'b1);
  endtask

  initial begin
    resetn = 1'b0; carry_in = 1'b0; ajuste = 1'b0; KEY_min = 1'b1; KEY_hora = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_hex", {hex_sd, hex_mu, hex_md, hex_hu, hex_hd}, {5{7'b0000001}});
    check("rst_co", carry_out, 1'b0);
    check("rst_pm", pm, 1'b0);
    resetn = 1'b1;
    t = 0;
    step(1'b0, 1'b0);

    // six pulses make one minute
    repeat (6) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check("t2_mu", hex_mu, 7'b1001111);
    check("t2_sd", hex_sd, 7'b0000001);

    repeat (1500) step($urandom_range(0, 1), 1'b1);

    // asynchronous reset in the middle of a count
    @(posedge clock); #3;
    resetn = 1'b0;
    #1;
    check("mid_rst_hex", {hex_sd, hex_mu, hex_md, hex_hu, hex_hd}, {5{7'b0000001}});
    check("mid_rst_co", carry_out, 1'b0);
    check("mid_rst_pm", pm, 1'b0);
    @(posedge clock); #1;
    resetn = 1'b1;
    t = 0;
    step(1'b0, 1'b0);

    // set 23:59 and roll over the day
    ajuste = 1'b1;
    step(1'b1, 1'b1);
    repeat (23) press(1'b0, 1'b1, 30, 1'b0);
    repeat (59) press(1'b1, 1'b0, 30, 1'b0);
    ajuste = 1'b0;
    step(1'b0, 1'b1);
    nco = 0;
    repeat (6) step(1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b1);
    check("wrap_pulses", nco, 1);
    check("wrap_hex", {hex_sd, hex_mu, hex_md, hex_hu, hex_hd}, exp_hex(0));

    // set mode ignores carry; 61 minute presses from 00 give 01
    ajuste = 1'b1;
    repeat (10) step(1'b1, 1'b1);
    repeat (61) press(1'b1, 1'b0, 30, 1'b0);
    check("t4_mu", hex_mu, 7'b1001111);
    check("t4_md", hex_md, 7'b0000001);

    // short glitch rejected, long hold counts once
    press(1'b0, 1'b1, 5, 1'b0);
    press(1'b0, 1'b1, 100, 1'b0);
    repeat (3) step(1'b0, 1'b1);

    repeat (30) begin
      logic km, kh;
      ajuste = $urandom_range(0, 1);
      step($urandom_range(0, 1), 1'b1);
      km = $urandom_range(0, 1);
      kh = $urandom_range(0, 1);
      if (!km && !kh) km = 1'b1;
      press(km, kh, ($urandom_range(0, 3) == 0) ? 5 : 30 + $urandom_range(0, 20), !ajuste);
      repeat ($urandom_range(5, 40)) step($urandom_range(0, 1), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
